// File: rtl/codificador_pkg.sv
// -----------------------------------------------------------------------------
// codificador_pkg
// Shared definitions for the 7-segment read-back decoder (codificador_num):
//   - active-low segment patterns {a,b,c,d,e,f,g} for digits 0..7 and blank
//   - report record and FSM state encoding
//   - helper to size the stability counter
//   - combinational classifier {seg, dp} -> report
// -----------------------------------------------------------------------------
package codificador_pkg;

  // Active-low segment patterns, bit order {a,b,c,d,e,f,g}.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // One report as presented to the consumer.
  typedef struct packed {
    logic [2:0] num;
    logic       blank;
    logic       erro;
  } report_t;

  // Counter must be able to hold the value STABLE_CYCLES itself.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

  // Any lit decimal point or unknown pattern is an error; num stays 0
  // for blank and error so the consumer sees a clean code.
  function automatic report_t classify(input logic [6:0] seg, input logic dp);
    report_t r;
    r = '0;
    if (!dp) begin
      r.erro = 1'b1;
    end else begin
      case (seg)
        SEG_0:     r.num = 3'd0;
        SEG_1:     r.num = 3'd1;
        SEG_2:     r.num = 3'd2;
        SEG_3:     r.num = 3'd3;
        SEG_4:     r.num = 3'd4;
        SEG_5:     r.num = 3'd5;
        SEG_6:     r.num = 3'd6;
        SEG_7:     r.num = 3'd7;
        SEG_BLANK: r.blank = 1'b1;
        default:   r.erro = 1'b1;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/codificador_num_if.sv
// -----------------------------------------------------------------------------
// codificador_num_if
// Report channel of codificador_num: recovered digit plus status flags,
// qualified by a valid/ready handshake, and the sticky overrun flag.
//   master (decoder) : drives num_out, blank_out, erro_out, out_valid, overrun
//   slave  (consumer): drives out_ready
// -----------------------------------------------------------------------------
interface codificador_num_if;
  logic [2:0] num_out;
  logic       blank_out;
  logic       erro_out;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;

  modport master (
    output num_out, blank_out, erro_out, out_valid, overrun,
    input  out_ready
  );

  modport slave (
    input  num_out, blank_out, erro_out, out_valid, overrun,
    output out_ready
  );
endinterface

// File: rtl/codificador_num_sincronizador.sv
// -----------------------------------------------------------------------------
// sincronizador
// STAGES-deep flop chain bringing an asynchronous WIDTH-bit bus into the clk
// domain. Resets to all ones, which on an active-low display is "all off".
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input bus
//   q          : synchronized output (last stage)
// -----------------------------------------------------------------------------
module sincronizador #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff [STAGES];

  // NOTE: this array is a chain of discrete flops, not a RAM, so resetting
  // every element is cheap and keeps the chain from reporting stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) ff[i] <= '1;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/codificador_num.sv
// -----------------------------------------------------------------------------
// codificador_num
// Reads back an active-low 7-segment bus, filters glitches and recovers the
// displayed digit 0..7. Each new stable pattern is reported once on rpt.
//   clk, rst_n : clock, asynchronous active-low reset
//   seg_in     : {a,b,c,d,e,f,g}, active-low, asynchronous to clk
//   dp_in      : decimal point, active-low (expected off = 1)
//   rpt        : report channel (num/blank/erro, valid/ready, sticky overrun)
// Latency from the first edge sampling a new pattern to out_valid is
// SYNC_STAGES + STABLE_CYCLES edges.
// -----------------------------------------------------------------------------
module codificador_num
  import codificador_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         seg_in,
  input  logic               dp_in,
  codificador_num_if.master  rpt
);

  localparam int                CNT_W   = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [7:0]       samp;        // synchronized {seg, dp}
  logic [7:0]       prev_q;      // previous synchronized sample
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             same;
  logic             stable_hit;
  logic             new_ev;
  report_t          cls;
  report_t          last_q;      // last report loaded into the outputs
  logic             last_vld_q;  // cleared by reset: nothing reported yet
  state_t           state_q;

  sincronizador #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (8)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({seg_in, dp_in}),
    .q     (samp)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    same    = (samp == prev_q);
    cnt_nxt = cnt_q;
    if (!same)                cnt_nxt = CNT_W'(1);
    else if (cnt_q != CNT_MAX) cnt_nxt = cnt_q + CNT_W'(1);
    // Fires only on the cycle the count reaches the threshold, so a
    // saturated pattern does not keep re-triggering (and a dropped
    // pattern stays dropped).
    stable_hit = (cnt_nxt == CNT_MAX) && (!same || (cnt_q != CNT_MAX));
    cls        = classify(samp[7:1], samp[0]);
    // Compared on the decoded report, so two different error patterns in
    // a row are one event, not two.
    new_ev     = stable_hit && (!last_vld_q || (cls != last_q));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 8'hFF;
      cnt_q  <= '0;
    end else begin
      prev_q <= samp;
      cnt_q  <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rpt.num_out   <= '0;
      rpt.blank_out <= 1'b0;
      rpt.erro_out  <= 1'b0;
      rpt.out_valid <= 1'b0;
      rpt.overrun   <= 1'b0;
      last_q        <= '0;
      last_vld_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (new_ev) begin
            rpt.num_out   <= cls.num;
            rpt.blank_out <= cls.blank;
            rpt.erro_out  <= cls.erro;
            rpt.out_valid <= 1'b1;
            last_q        <= cls;
            last_vld_q    <= 1'b1;
            state_q       <= PEND;
          end
        end
        PEND: begin
          if (rpt.out_ready) begin
            if (new_ev) begin
              // Consumer frees the slot on the same edge: hand over the
              // new report back-to-back instead of dropping it.
              rpt.num_out   <= cls.num;
              rpt.blank_out <= cls.blank;
              rpt.erro_out  <= cls.erro;
              last_q        <= cls;
            end else begin
              rpt.out_valid <= 1'b0;
              state_q       <= IDLE;
            end
          end else if (new_ev) begin
            rpt.overrun <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codificador_num.sv
// -----------------------------------------------------------------------------
// tb_codificador_num
// Directed bench for codificador_num with default parameters
// (STABLE_CYCLES=4, SYNC_STAGES=2 -> 6-edge report latency).
// -----------------------------------------------------------------------------
module tb_codificador_num;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       dp_in;

  int n_total;
  int n_bad;

  codificador_num_if rpt ();

  codificador_num dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seg_in (seg_in),
    .dp_in  (dp_in),
    .rpt    (rpt.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written digit table, active-low {a..g}.
  logic [6:0] tbl [8];
  initial begin
    tbl[0] = 7'b0000001; tbl[1] = 7'b1001111;
    tbl[2] = 7'b0010010; tbl[3] = 7'b0000110;
    tbl[4] = 7'b1001100; tbl[5] = 7'b0100100;
    tbl[6] = 7'b0100000; tbl[7] = 7'b0001111;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Count cycles with out_valid high over a window; remember last report.
  task automatic watch(input int n, output int pulses, output logic [2:0] num,
                       output logic erro);
    pulses = 0;
    num    = '0;
    erro   = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick(1);
      if (rpt.out_valid) begin
        pulses++;
        num  = rpt.num_out;
        erro = rpt.erro_out;
      end
    end
  endtask

  int         pulses;
  logic [2:0] wnum;
  logic       werr;

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    seg_in  = 7'b1111111;
    dp_in   = 1'b1;
    rpt.out_ready = 1'b0;
    #1;
    check("rst_valid",   32'(rpt.out_valid), 32'd0);
    check("rst_num",     32'(rpt.num_out),   32'd0);
    check("rst_blank",   32'(rpt.blank_out), 32'd0);
    check("rst_erro",    32'(rpt.erro_out),  32'd0);
    check("rst_overrun", 32'(rpt.overrun),   32'd0);
    tick(2);

    // 1: digit 3 after reset, 6-edge latency, held until accepted.
    seg_in = 7'b0000110;
    rst_n  = 1'b1;
    tick(5);
    check("t1_valid_e5", 32'(rpt.out_valid), 32'd0);
    tick(1);
    check("t1_valid_e6", 32'(rpt.out_valid), 32'd1);
    check("t1_num",      32'(rpt.num_out),   32'd3);
    check("t1_erro",     32'(rpt.erro_out),  32'd0);
    tick(3);
    check("t1_held",     32'(rpt.out_valid), 32'd1);
    check("t1_held_num", 32'(rpt.num_out),   32'd3);
    rpt.out_ready = 1'b1;
    tick(1);
    check("t1_drop",     32'(rpt.out_valid), 32'd0);
    rpt.out_ready = 1'b0;

    // 2: digit 6, then a 2-cycle glitch to 1 that must be filtered.
    seg_in = 7'b0100000;
    tick(6);
    check("t2_valid", 32'(rpt.out_valid), 32'd1);
    check("t2_num",   32'(rpt.num_out),   32'd6);
    rpt.out_ready = 1'b1;
    tick(1);
    check("t2_drop",  32'(rpt.out_valid), 32'd0);
    seg_in = 7'b1001111;
    tick(2);
    seg_in = 7'b0100000;
    watch(12, pulses, wnum, werr);
    check("t2_glitch_reports", 32'(pulses), 32'd0);
    check("t2_num_kept",       32'(rpt.num_out), 32'd6);
    rpt.out_ready = 1'b0;

    // 3: blank, then dp lit (error), then a different error pattern.
    seg_in = 7'b1111111;
    dp_in  = 1'b1;
    tick(6);
    check("t3_blank_valid", 32'(rpt.out_valid), 32'd1);
    check("t3_blank",       32'(rpt.blank_out), 32'd1);
    check("t3_blank_num",   32'(rpt.num_out),   32'd0);
    check("t3_blank_erro",  32'(rpt.erro_out),  32'd0);
    rpt.out_ready = 1'b1;
    tick(1);
    rpt.out_ready = 1'b0;
    seg_in = 7'b0000001;
    dp_in  = 1'b0;
    tick(6);
    check("t3_dp_valid", 32'(rpt.out_valid), 32'd1);
    check("t3_dp_erro",  32'(rpt.erro_out),  32'd1);
    check("t3_dp_num",   32'(rpt.num_out),   32'd0);
    check("t3_dp_blank", 32'(rpt.blank_out), 32'd0);
    rpt.out_ready = 1'b1;
    tick(1);
    rpt.out_ready = 1'b0;
    seg_in = 7'b1010101;
    watch(10, pulses, wnum, werr);
    check("t3_err2_reports", 32'(pulses), 32'd0);
    check("t3_err2_erro",    32'(rpt.erro_out), 32'd1);

    // 4: overrun, then ready coinciding with a new event.
    dp_in  = 1'b1;
    seg_in = 7'b0001111;
    tick(6);
    check("t4_num7",      32'(rpt.num_out), 32'd7);
    check("t4_ovr_clear", 32'(rpt.overrun), 32'd0);
    seg_in = 7'b1001100;
    tick(6);
    check("t4_valid_kept", 32'(rpt.out_valid), 32'd1);
    check("t4_num_frozen", 32'(rpt.num_out),   32'd7);
    check("t4_overrun",    32'(rpt.overrun),   32'd1);
    seg_in = 7'b0100100;
    tick(5);
    rpt.out_ready = 1'b1;
    tick(1);
    rpt.out_ready = 1'b0;
    check("t4_reload_valid", 32'(rpt.out_valid), 32'd1);
    check("t4_reload_num",   32'(rpt.num_out),   32'd5);
    tick(2);
    check("t4_ovr_sticky",   32'(rpt.overrun),   32'd1);
    check("t4_still_pend",   32'(rpt.out_valid), 32'd1);

    // 5: reset mid-PEND, then the same digit is reported again.
    rst_n = 1'b0;
    #2;
    check("t5_async_valid",   32'(rpt.out_valid), 32'd0);
    check("t5_async_overrun", 32'(rpt.overrun),   32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("t5_valid_e5", 32'(rpt.out_valid), 32'd0);
    tick(1);
    check("t5_valid_e6", 32'(rpt.out_valid), 32'd1);
    check("t5_num",      32'(rpt.num_out),   32'd5);
    rpt.out_ready = 1'b1;
    tick(1);
    check("t5_drop",     32'(rpt.out_valid), 32'd0);

    // 6: sweep all digits with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      seg_in = tbl[i];
      watch(10, pulses, wnum, werr);
      check($sformatf("t6_reports_%0d", i), 32'(pulses), 32'd1);
      check($sformatf("t6_num_%0d", i),     32'(wnum),   32'(i));
      check($sformatf("t6_erro_%0d", i),    32'(werr),   32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
